mux_gate_pipe: RTL
==================

MUX_GATE_PIPE -- requirements
Module: mux_gate_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 1..64).
REQ-002 SHALL have parameter OP_W, default 3, opcode width (fixed 3; other values are illegal and SHALL be caught by an elaboration-time check).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream request valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts request this cycle.
REQ-007 SHALL have port a, input, WIDTH, operand A.
REQ-008 SHALL have port b, input, WIDTH, operand B.
REQ-009 SHALL have port op, input, OP_W, gate select.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port y, output, WIDTH, registered result.
REQ-013 SHALL have port y_op, output, OP_W, opcode that produced y.

Function
REQ-014 SHALL decode op as: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a (b ignored), 7 BUF a (b ignored); all operations are bitwise across WIDTH.
REQ-015 SHALL build every result bit from 2:1 multiplexers only, with a selecting between constants, b or ~b; no behavioural operators in the gate path.
REQ-016 SHALL accept a request on a cycle where in_valid && in_ready; stage 1 registers a, b and op.
REQ-017 SHALL compute the gate from stage-1 registers and register y/y_op in stage 2, giving 2-cycle latency from acceptance to out_valid with out_ready held high.
REQ-018 SHALL sustain 1 result/cycle when out_ready is held high.
REQ-019 SHALL hold y, y_op and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL drive in_ready = !s1_valid || (!s2_valid || out_ready), with combinational ready chaining; in_valid is never used to form in_ready.
REQ-021 SHALL, when the pipeline is full and out_ready is low, deassert in_ready; accepting no data in this state is the required behaviour, not an overflow.
REQ-022 SHALL, on a same-cycle output handshake and input acceptance, advance both stages with no bubble and no loss.
REQ-023 SHALL ignore a, b and op when in_valid is low.

Reset
REQ-024 SHALL, while rst_n is low, clear s1_valid, s2_valid, out_valid, y and y_op to 0 (in_ready therefore reads 1).
REQ-025 SHALL, on reset assertion mid-operation, discard all in-flight results asynchronously; no result is presented after release.
REQ-026 SHALL allow acceptance on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro MUX_GATE_PIPE_STATS_EN defined, add output port txn_count[15:0]: it counts output handshakes, saturates at 16'hFFFF and is cleared by reset.
REQ-028 SHALL, without MUX_GATE_PIPE_STATS_EN, omit the txn_count port and the counter logic; all other behaviour is identical.

Structure
REQ-029 SHALL place the opcode enum gate_op_e (AND..BUF) and the OP_W constant in package mux_gate_pkg, shared with the testbench.
REQ-030 SHALL implement the per-bit mux network as sub-module mux_gate_bit (inputs a, b, op; output y), instantiated WIDTH times with a generate loop.

Verification (WIDTH=8)
REQ-031 SHALL cover: after reset, a=8'hF0, b=8'hCC, op=0..7 back-to-back with out_ready=1 -> y = C0, FC, 3F, 03, 3C, C3, 0F, F0, each 2 cycles after acceptance, with y_op matching.
REQ-032 SHALL cover: 3 requests accepted, then out_ready=0 for 5 cycles -> in_ready=0 once 2 results are held, y held stable, and all 3 results delivered in order when out_ready returns to 1.
REQ-033 SHALL cover: random in_valid/out_ready at 50% duty over 1000 requests -> every result matches the reference model, with no drops and no duplicates.
REQ-034 SHALL cover: rst_n pulsed low with 2 results in flight -> out_valid=0 immediately, and no stale result appears after release.
REQ-035 SHALL cover: with MUX_GATE_PIPE_STATS_EN defined, 65540 handshakes -> txn_count=16'hFFFF; after reset, txn_count=0.
REQ-036 SHALL cover: WIDTH=1 and WIDTH=64 builds, op=4 with a=all-ones and b=alternating 1/0 pattern -> y = bitwise inverse of b.

Source files
------------

// File: rtl/mux_gate_pkg.sv
// Shared opcode definitions for the mux_gate_pipe block and its bench.
// Used by mux_gate_bit, mux_gate_pipe and tb_mux_gate_pipe.
package mux_gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_BUF  = 3'd7
    } gate_op_e;

endpackage

// File: rtl/mux_gate_bit.sv
// One result bit of the gate, built purely from 2:1 multiplexers.
// Operand a steers each leaf between constants, b and ~b; op then picks a leaf.
module mux_gate_bit
    import mux_gate_pkg::*;
(
    input  logic            a,
    input  logic            b,
    input  logic [OP_W-1:0] op,
    output logic            y
);

    logic       b_n;
    logic [7:0] leaf;
    logic [3:0] lvl1;
    logic [1:0] lvl2;

    assign b_n = ~b;

    // Leaf index equals the opcode value (AND, OR, NAND, NOR, XOR, XNOR, NOT, BUF).
    assign leaf[0] = a ? b    : 1'b0;
    assign leaf[1] = a ? 1'b1 : b;
    assign leaf[2] = a ? b_n  : 1'b1;
    assign leaf[3] = a ? 1'b0 : b_n;
    assign leaf[4] = a ? b_n  : b;
    assign leaf[5] = a ? b    : b_n;
    assign leaf[6] = a ? 1'b0 : 1'b1;
    assign leaf[7] = a ? 1'b1 : 1'b0;

    assign lvl1[0] = op[0] ? leaf[1] : leaf[0];
    assign lvl1[1] = op[0] ? leaf[3] : leaf[2];
    assign lvl1[2] = op[0] ? leaf[5] : leaf[4];
    assign lvl1[3] = op[0] ? leaf[7] : leaf[6];

    assign lvl2[0] = op[1] ? lvl1[1] : lvl1[0];
    assign lvl2[1] = op[1] ? lvl1[3] : lvl1[2];

    assign y = op[2] ? lvl2[1] : lvl2[0];

endmodule

// File: rtl/mux_gate_pipe.sv
// Two-stage valid/ready pipeline applying a bitwise gate selected by op.
// Optional MUX_GATE_PIPE_STATS_EN adds a saturating output-handshake counter txn_count.
module mux_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [OP_W-1:0]  y_op
`ifdef MUX_GATE_PIPE_STATS_EN
    ,
    output logic [15:0]      txn_count
`endif
);

    if (OP_W != mux_gate_pkg::OP_W) begin : g_op_w_check
        $error("mux_gate_pipe: OP_W must be 3");
    end

    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("mux_gate_pipe: WIDTH must be in 1..64");
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic             s2_valid;
    logic             s1_ready;
    logic             s2_ready;
    logic [WIDTH-1:0] gate_y;

    // Handshake: a transfer happens on a rising edge where valid && ready; valid
    // never waits on ready, and ready is formed from downstream state only.
    assign s2_ready  = !s2_valid || out_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign in_ready  = !s1_valid || (!s2_valid || out_ready);
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_gate_bit u_bit (
            .a  (s1_a[i]),
            .b  (s1_b[i]),
            .op (s1_op),
            .y  (gate_y[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y        <= '0;
            y_op     <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y    <= gate_y;
                y_op <= s1_op;
            end
        end
    end

`ifdef MUX_GATE_PIPE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (s2_valid && out_ready && txn_count != 16'hFFFF) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`endif

endmodule
